// File: rtl/booth4_seq_mult.sv
// booth4_seq_mult: iterative radix-4 Booth multiplier.
// One Booth digit is retired per clock. The multiples {0, +A, +2A, -A, -2A}
// are formed at operand width. A shift-right-2 accumulator adds each
// multiple at the top of a wide window, so the whole product stays exact.
// is_signed chooses between two's-complement and unsigned operands.
// It is applied once, when the operands are extended at accept.

module booth4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Number of Booth digits. The extended multiplier is WIDTH+2 bits wide,
  // so the digit count is the same in signed and unsigned mode.
  localparam int N  = WIDTH / 2 + 1;
  // Width of a signed multiple (covers +/-2*A_x with A_x at WIDTH+1 bits).
  localparam int MW = WIDTH + 3;
  // Upper accumulator window: one guard bit above a multiple. This leaves
  // headroom for the running partial sum.
  localparam int HW = WIDTH + 4;
  // Lower window: every digit is shifted down by two bits. After N digits
  // the first digit has reached bit 0.
  localparam int LW = 2 * N;
  localparam int AW = HW + LW;
  localparam int CW = $clog2(N + 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth4_seq_mult: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Latched operands. b_sh carries B_x with the implicit B_x[-1]=0 at bit 0.
  logic [WIDTH:0]        a_x;
  logic [WIDTH+2:0]      b_sh;
  logic [CW-1:0]         cnt;
  logic signed [AW-1:0]  acc;

  // Operand extension and datapath terms.
  logic [WIDTH:0]        ext_a;
  logic [WIDTH+2:0]      ext_b;
  logic [2:0]            digit;
  logic [MW-1:0]         m1;
  logic [MW-1:0]         m2;
  logic [MW-1:0]         mult;
  logic signed [AW-1:0]  add_term;
  logic signed [AW-1:0]  acc_sum;
  logic signed [AW-1:0]  acc_next;
  logic                  last_step;
  logic                  accept;

  assign ext_a = {is_signed & a[WIDTH-1], a};
  assign ext_b = {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};

  assign digit = b_sh[2:0];
  assign m1    = {{2{a_x[WIDTH]}}, a_x};
  assign m2    = {m1[MW-2:0], 1'b0};

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (cnt == CW'(N - 1));

  // Select the Booth multiple for the digit currently at the bottom of b_sh.
  always_comb begin
    mult = '0;
    unique case (digit)
      3'b001, 3'b010: mult = m1;
      3'b011:         mult = m2;
      3'b100:         mult = -m2;
      3'b101, 3'b110: mult = -m1;
      default:        mult = '0;
    endcase
  end

  // Add the multiple at the top of the window, then shift the sum down two bits.
  always_comb begin
    add_term = {mult[MW-1], mult, {LW{1'b0}}};
    acc_sum  = acc + add_term;
    acc_next = acc_sum >>> 2;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, retire N digits, pulse DONE for one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latching, digit retirement and the product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_x     <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      acc     <= '0;
      product <= '0;
    end else if (accept) begin
      a_x  <= ext_a;
      b_sh <= ext_b;
      cnt  <= '0;
      acc  <= '0;
    end else if (state == RUN) begin
      acc  <= acc_next;
      b_sh <= {2'b00, b_sh[WIDTH+2:2]};
      cnt  <= cnt + CW'(1);
      if (last_step) begin
        product <= acc_next[2*WIDTH-1:0];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth4_seq_mult.sv
// tb_booth4_seq_mult: randomized and directed bench for booth4_seq_mult at WIDTH=8.
// Expected products come from plain integer multiplication of the operands
// under the selected signedness.

module tb_booth4_seq_mult;

  localparam int WIDTH = 8;
  localparam int NDIG  = WIDTH / 2 + 1;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  int assert_count = 0;
  int fail_count   = 0;

  booth4_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: an ordinary integer multiply, truncated to 2*WIDTH bits.
  function automatic logic [15:0] refProduct(input logic [7:0] x, input logic [7:0] y,
                                             input logic sgn);
    int sx;
    int sy;
    int px;
    if (sgn) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
    end else begin
      sx = int'({24'b0, x});
      sy = int'({24'b0, y});
    end
    px = sx * sy;
    return px[15:0];
  endfunction

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Run one full operation.
  // hold keeps start high after the accept edge.
  // scramble changes the operand inputs while the operation is in flight.
  task automatic applyStimulus(input logic [7:0] op_a, input logic [7:0] op_b,
                               input logic sgn, input bit hold, input bit scramble,
                               input string tag);
    int busy_cycles;
    int guard;
    logic [15:0] exp_p;
    exp_p = refProduct(op_a, op_b, sgn);
    @(negedge clk);
    a = op_a; b = op_b; is_signed = sgn; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    if (scramble) begin
      a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
    end
    busy_cycles = 0;
    guard = 0;
    while (!done && guard < 20) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      guard++;
    end
    checkOutput({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_busy_cycles"}, busy_cycles, NDIG);
    checkOutput({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_product"}, {16'b0, product}, {16'b0, exp_p});
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse_len"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_product_hold"}, {16'b0, product}, {16'b0, exp_p});
  endtask

  logic [7:0] corners [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

  // Main stimulus sequence.
  initial begin
    int done_seen;
    int accepts;
    logic prev_busy;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_product", {16'b0, product}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed cases with known constants.
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, "ff_unsigned");
    checkOutput("ff_unsigned_const", {16'b0, product}, 32'h0000FE01);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, "ff_signed");
    checkOutput("ff_signed_const", {16'b0, product}, 32'h00000001);
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, "min_min");
    checkOutput("min_min_const", {16'b0, product}, 32'h00004000);
    applyStimulus(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, "min_max");
    checkOutput("min_max_const", {16'b0, product}, 32'h0000C080);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, "zero_neg1");
    checkOutput("zero_neg1_const", {16'b0, product}, 32'h00000000);

    // Corner operand grid in both modes.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          applyStimulus(corners[i], corners[j], 1'(s), 1'b0, 1'b0, "corner");

    // Start held high: one done per accept, next accept two cycles after done.
    @(negedge clk);
    a = 8'd13; b = 8'd11; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    prev_busy = busy;
    done_seen = 0;
    accepts = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin
        a = 8'd200; b = 8'd3;
      end
      @(posedge clk); #1;
      if (done) begin
        done_seen++;
        if (done_seen == 1) begin
          checkOutput("hs_done1_cycle", c, 5);
          checkOutput("hs_product1", {16'b0, product}, 32'd143);
        end else if (done_seen == 2) begin
          checkOutput("hs_done2_cycle", c, 12);
          checkOutput("hs_product2", {16'b0, product}, {16'b0, refProduct(8'd200, 8'd3, 1'b0)});
        end
      end
      if (busy && !prev_busy) begin
        accepts++;
        checkOutput("hs_reaccept_cycle", c, 7 * accepts);
      end
      prev_busy = busy;
    end
    start = 1'b0;
    checkOutput("hs_done_count", done_seen, 3);
    checkOutput("hs_accept_count", accepts, 2);
    repeat (2) @(posedge clk);

    // Reset in the middle of an operation.
    applyStimulus(8'd100, 8'd50, 1'b0, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    a = 8'd77; b = 8'd99; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
    checkOutput("rst_mid_product", {16'b0, product}, 32'd0);
    @(negedge clk); rst = 1'b0;
    done_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    checkOutput("rst_no_done", done_seen, 0);
    checkOutput("rst_product_kept_zero", {16'b0, product}, 32'd0);
    applyStimulus(8'd77, 8'd99, 1'b0, 1'b0, 1'b0, "post_rst");

    // Randomized operations. Some have their inputs changed while in flight.
    for (int n = 0; n < 1500; n++)
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
